// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the adder-sharing arbiter and its round-robin picker.
package adder_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int DEF_N    = 32;
   localparam int DEF_NREQ = 4;

   // Low bit of requester idx's operand inside a packed NREQ*width bus
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping,
// reported both one-hot and as a binary index.
module rr_picker #(
   parameter int  NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   logic [IDW-1:0] cand_s;
   logic           hit_s;
   logic           found_s;

   // Walk the candidates in priority order; the first hit wins and masks the rest
   always_comb begin
      gnt     = {NREQ{1'b0}};
      gnt_idx = {IDW{1'b0}};
      cand_s  = {IDW{1'b0}};
      hit_s   = 1'b0;
      found_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s       = IDW'((int'(ptr) + k) % NREQ);
         hit_s        = en & ~found_s & req[cand_s];
         gnt[cand_s]  = gnt[cand_s] | hit_s;
         gnt_idx      = hit_s ? cand_s : gnt_idx;
         found_s      = found_s | hit_s;
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external adder among NREQ valid/ready requesters with round-robin
// arbitration and returns each result on a single ID-tagged response channel.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int  N    = DEF_N,
   parameter int  NREQ = DEF_NREQ,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [N-1:0]      add_a,
   output logic [N-1:0]      add_b,
   input  logic [N-1:0]      add_sum,
   input  logic              add_cout,
   input  logic              add_ovf,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [N-1:0]      rsp_sum,
   output logic              rsp_cout,
   output logic              rsp_overflow,
   output logic              busy
);

   state_e          state_r;
   state_e          state_nxt_s;
   logic [IDW-1:0]  ptr_r;
   logic [IDW-1:0]  id_r;
   logic [IDW-1:0]  gnt_idx_s;
   logic [NREQ-1:0] gnt_s;
   logic            win_s;
   logic            accept_s;
   logic [N-1:0]    sel_a_s;
   logic [N-1:0]    sel_b_s;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req     (req_valid),
      .ptr     (ptr_r),
      .en      (win_s),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // Accept window: idle, or the held result is being consumed this cycle
   always_comb begin
      win_s = (state_r == IDLE) | ((state_r == HOLD) & rsp_ready);
   end

   // State register; busy is registered from the next state so it tracks state != IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s != IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = CALC;
            else          state_nxt_s = IDLE;
         end
         CALC: state_nxt_s = HOLD;
         HOLD: begin
            if (rsp_ready && accept_s) state_nxt_s = CALC;
            else if (rsp_ready)        state_nxt_s = IDLE;
            else                       state_nxt_s = HOLD;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake outputs; the picker is disabled outside the window so gnt is already gated
   always_comb begin
      req_ready = gnt_s;
      accept_s  = |(req_valid & gnt_s);
   end

   // One-hot operand mux over the packed request buses
   always_comb begin
      sel_a_s = {N{1'b0}};
      sel_b_s = {N{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_a_s = sel_a_s | (req_a[slice_lo(i, N) +: N] & {N{gnt_s[i]}});
         sel_b_s = sel_b_s | (req_b[slice_lo(i, N) +: N] & {N{gnt_s[i]}});
      end
   end

   // Operand, owner and pointer registers; all hold between accepts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         add_a <= {N{1'b0}};
         add_b <= {N{1'b0}};
         id_r  <= {IDW{1'b0}};
         ptr_r <= {IDW{1'b0}};
      end else if (accept_s) begin
         add_a <= sel_a_s;
         add_b <= sel_b_s;
         id_r  <= gnt_idx_s;
         ptr_r <= (gnt_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1'b1);
      end else begin
         add_a <= add_a;
         add_b <= add_b;
         id_r  <= id_r;
         ptr_r <= ptr_r;
      end
   end

   // Response registers: capture in CALC, retire on a consumed HOLD with nothing new behind it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid    <= 1'b0;
         rsp_id       <= {IDW{1'b0}};
         rsp_sum      <= {N{1'b0}};
         rsp_cout     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         case (state_r)
            CALC: begin
               rsp_valid    <= 1'b1;
               rsp_id       <= id_r;
               rsp_sum      <= add_sum;
               rsp_cout     <= add_cout;
               rsp_overflow <= add_ovf;
            end
            HOLD: begin
               if (rsp_ready && !accept_s) rsp_valid <= 1'b0;
               else                        rsp_valid <= rsp_valid;
            end
            default: rsp_valid <= rsp_valid;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: cycle-level reference model checked every
// cycle, plus literal expectations for the headline scenarios.
module tb_adder_share_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [N-1:0]      add_a;
   logic [N-1:0]      add_b;
   logic [N-1:0]      add_sum;
   logic              add_cout;
   logic              add_ovf;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [N-1:0]      rsp_sum;
   logic              rsp_cout;
   logic              rsp_overflow;
   logic              busy;

   logic [N-1:0] opa [NREQ];
   logic [N-1:0] opb [NREQ];

   int tests;
   int fails;

   adder_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_sum      (add_sum),
      .add_cout     (add_cout),
      .add_ovf      (add_ovf),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_sum      (rsp_sum),
      .rsp_cout     (rsp_cout),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
   );

   // External adder attached to the DUT
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
   assign add_ovf = (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = opa[i];
         req_b[i*N +: N] = opb[i];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // Reference model: phase 0 = nothing held, 1 = operands on adder, 2 = result presented
   int           m_phase;
   int           m_ptr;
   int           m_id;
   bit           m_init;
   logic [N-1:0] m_add_a, m_add_b;
   logic         m_rsp_valid;
   int           m_rsp_id;
   logic [N-1:0] m_rsp_sum;
   logic         m_rsp_cout, m_rsp_ovf;

   initial begin
      m_init = 1'b0;
      forever begin
         @(negedge clk);
         begin
            bit            win;
            int            g;
            logic [NREQ-1:0] exp_rdy;
            logic [N:0]    wide;
            win = (m_phase == 0) || (m_phase == 2 && rsp_ready);
            g   = win ? pick(req_valid, m_ptr) : -1;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            if (rst_n && m_init) begin
               chk("req_ready", 64'(req_ready), 64'(exp_rdy));
               chk("busy", 64'(busy), 64'(m_phase != 0));
               chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
               chk("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
               chk("rsp_sum", 64'(rsp_sum), 64'(m_rsp_sum));
               chk("rsp_cout", 64'(rsp_cout), 64'(m_rsp_cout));
               chk("rsp_overflow", 64'(rsp_overflow), 64'(m_rsp_ovf));
               chk("add_a", 64'(add_a), 64'(m_add_a));
               chk("add_b", 64'(add_b), 64'(m_add_b));
            end
            if (!rst_n) begin
               m_init = 1'b1; m_phase = 0; m_ptr = 0; m_id = 0;
               m_add_a = '0; m_add_b = '0;
               m_rsp_valid = 1'b0; m_rsp_id = 0; m_rsp_sum = '0;
               m_rsp_cout = 1'b0; m_rsp_ovf = 1'b0;
            end else if (m_init) begin
               if (m_phase == 1) begin
                  wide        = {1'b0, m_add_a} + {1'b0, m_add_b};
                  m_rsp_sum   = wide[N-1:0];
                  m_rsp_cout  = wide[N];
                  m_rsp_ovf   = (m_add_a[N-1] == m_add_b[N-1]) && (wide[N-1] != m_add_a[N-1]);
                  m_rsp_id    = m_id;
                  m_rsp_valid = 1'b1;
               end else if (m_phase == 2 && rsp_ready && g < 0) begin
                  m_rsp_valid = 1'b0;
               end
               if (g >= 0) begin
                  m_add_a = opa[g];
                  m_add_b = opb[g];
                  m_id    = g;
                  m_ptr   = (g + 1) % NREQ;
                  m_phase = 1;
               end else if (m_phase == 1) m_phase = 2;
               else if (m_phase == 2 && rsp_ready) m_phase = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
      step(); step();
      rst_n = 1'b1;
      look();
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_add_a", 64'(add_a), 64'd0);

      // Single request, latency 2
      step();
      req_valid = 4'b0001; opa[0] = 32'd5; opb[0] = 32'd7;
      look();
      chk("single_ready", 64'(req_ready), 64'b0001);
      step();
      req_valid = 4'b0000;
      look();
      chk("single_calc_busy", 64'(busy), 64'd1);
      chk("single_calc_nvalid", 64'(rsp_valid), 64'd0);
      step();
      look();
      chk("single_valid", 64'(rsp_valid), 64'd1);
      chk("single_sum", 64'(rsp_sum), 64'd12);
      chk("single_id", 64'(rsp_id), 64'd0);
      chk("single_cout", 64'(rsp_cout), 64'd0);
      chk("single_ovf", 64'(rsp_overflow), 64'd0);
      step();
      rsp_ready = 1'b1;
      look();
      chk("single_hold", 64'(rsp_valid), 64'd1);
      step();
      look();
      chk("single_retire", 64'(rsp_valid), 64'd0);
      chk("single_idle", 64'(busy), 64'd0);

      // All four requesting continuously: ids rotate 0,1,2,3,0 every 2 cycles
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = 32'(i * 100 + 1);
         opb[i] = 32'(10 + i);
      end
      for (int k = 0; k < 5; k++) begin
         step(); step();
         look();
         chk("rr_valid", 64'(rsp_valid), 64'd1);
         chk("rr_id", 64'(rsp_id), 64'(k % NREQ));
         chk("rr_sum", 64'(rsp_sum), 64'(101 * (k % NREQ) + 11));
      end
      step();
      req_valid = 4'b0000;
      step(); step(); step();

      // Backpressure: result held for 5 cycles, then the pending request is taken
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      opa[0] = 32'h10;   opb[0] = 32'h20;
      opa[1] = 32'h1000; opb[1] = 32'h2000;
      step(); step();
      for (int j = 0; j < 5; j++) begin
         look();
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_sum", 64'(rsp_sum), 64'h30);
         chk("bp_id", 64'(rsp_id), 64'd0);
         chk("bp_ready", 64'(req_ready), 64'd0);
         chk("bp_busy", 64'(busy), 64'd1);
         step();
      end
      rsp_ready = 1'b1;
      look();
      chk("bp_release_ready", 64'(req_ready), 64'b0010);
      step();
      req_valid = 4'b0000;
      step();
      look();
      chk("bp_next_id", 64'(rsp_id), 64'd1);
      chk("bp_next_sum", 64'(rsp_sum), 64'h3000);
      step(); step();

      // Signed overflow
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b0001; opa[0] = 32'h7FFF_FFFF; opb[0] = 32'h1;
      step();
      req_valid = 4'b0000;
      step();
      look();
      chk("ovf_sum", 64'(rsp_sum), 64'h8000_0000);
      chk("ovf_ovf", 64'(rsp_overflow), 64'd1);
      chk("ovf_cout", 64'(rsp_cout), 64'd0);

      // Unsigned carry from requester 2 (pointer now at 1)
      step();
      req_valid = 4'b0100; opa[2] = 32'hFFFF_FFFF; opb[2] = 32'h1;
      step();
      req_valid = 4'b0000;
      step();
      look();
      chk("carry_sum", 64'(rsp_sum), 64'd0);
      chk("carry_cout", 64'(rsp_cout), 64'd1);
      chk("carry_ovf", 64'(rsp_overflow), 64'd0);
      chk("carry_id", 64'(rsp_id), 64'd2);

      // Reset while in CALC discards the transaction and rewinds the pointer
      step();
      req_valid = 4'b0010; opa[1] = 32'h1234; opb[1] = 32'h1;
      look();
      chk("rst_calc_grant", 64'(req_ready), 64'b0010);
      step();
      rst_n = 1'b0;
      req_valid = 4'b0000;
      look();
      chk("rst_calc_busy", 64'(busy), 64'd1);
      step();
      rst_n = 1'b1;
      req_valid = 4'b0101;
      opa[0] = 32'd3; opb[0] = 32'd4; opa[2] = 32'd9; opb[2] = 32'd9;
      look();
      chk("rst_calc_nvalid", 64'(rsp_valid), 64'd0);
      chk("rst_calc_idle", 64'(busy), 64'd0);
      chk("rst_calc_sum0", 64'(rsp_sum), 64'd0);
      chk("rst_calc_adda0", 64'(add_a), 64'd0);
      chk("rst_calc_ptr0", 64'(req_ready), 64'b0001);
      step();
      req_valid = 4'b0000;
      step();
      look();
      chk("rst_calc_after_id", 64'(rsp_id), 64'd0);
      chk("rst_calc_after_sum", 64'(rsp_sum), 64'd7);
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one N-bit carry-lookahead adder among NREQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel. All requesters share one valid/ready response channel tagged with the requester ID.
- The adder is outside this block. This block drives its registered operands and captures its sum, carry-out and overflow.
- Sits between the ALU-side requesters and the shared adder datapath.

Parameters:
N, 32, operand and sum width in bits
NREQ, 4, number of requesters (≥2)
IDW, $clog2(NREQ), requester ID width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  NREQ*N  packed operand A; requester i uses bits [i*N +: N]
req_b  in  NREQ*N  packed operand B, same packing
add_a  out  N  registered operand A to adder
add_b  out  N  registered operand B to adder
add_sum  in  N  adder sum (combinational from add_a/add_b)
add_cout  in  1  adder carry-out
add_ovf  in  1  adder signed overflow
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_id  out  IDW  index of the requester that owns the result
rsp_sum  out  N  registered sum
rsp_cout  out  1  registered carry-out
rsp_overflow  out  1  registered overflow
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge) sets:
  - state=IDLE, ptr=0
  - add_a=0, add_b=0
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_overflow=0
  - Reset mid-operation discards the transaction; no response is produced.
- States:
  - IDLE: no transaction held.
  - CALC: operands are on the adder.
  - HOLD: a result is presented on the response channel.
- Accept window: the cycle is in IDLE, or in HOLD with rsp_ready=1.
- Arbitration:
  - Within an accept window, grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally that cycle; all other bits are 0. If no request is valid, req_ready=0.
- Accept (req_valid[g] & req_ready[g]):
  - add_a <= req_a[g], add_b <= req_b[g], id register <= g.
  - ptr <= (g+1) mod NREQ; ptr is unchanged on cycles with no accept.
  - State moves to CALC.
- CALC (exactly 1 cycle):
  - rsp_sum/rsp_cout/rsp_overflow <= add_sum/add_cout/add_ovf; rsp_id <= id register; rsp_valid <= 1.
  - State moves to HOLD.
- HOLD:
  - Response outputs are stable while rsp_ready=0.
  - On rsp_ready=1 with a new accept: go to CALC. rsp_valid stays 1 and rsp_* are overwritten by the next result one cycle later.
  - On rsp_ready=1 with no accept: rsp_valid <= 0, go to IDLE.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid=1 at T+2.
  - Peak throughput is one result per 2 cycles.
- Requester obligations:
  - Hold req_valid, req_a and req_b stable until accepted.
  - req_valid must not depend combinationally on req_ready.
- req_valid dropping before accept is tolerated; that requester is simply not granted.
- Arithmetic: none inside this block. Sum, cout and overflow are taken verbatim from the adder (two's complement, carry-in 0).
- add_a/add_b hold their last values outside CALC.

Decomposition:
- Package adder_share_pkg:
  - state enum {IDLE, CALC, HOLD}
  - default N/NREQ localparams
  - function for the req_a/req_b slice index
- Sub-module rr_picker:
  - Inputs: NREQ request vector, ptr, enable.
  - Outputs: one-hot grant and binary grant index.
  - Purely combinational; the top level holds ptr and the FSM.

Test Plan:
- Single request: req_valid=0001, A=5, B=7 → req_ready=0001 at T; rsp_valid at T+2 with sum=12, id=0, cout=0, ovf=0.
- All four valid continuously, rsp_ready=1, ptr=0 after reset → ids 0,1,2,3,0 in order, one result every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in HOLD → rsp_* stable, req_ready=0, busy=1; releasing rsp_ready accepts the pending request.
- Overflow: A=0x7FFFFFFF, B=1 (adder model attached) → sum=0x80000000, ovf=1, cout=0.
- Carry: A=0xFFFFFFFF, B=1 → sum=0, cout=1, ovf=0.
- Reset in CALC: rst_n=0 for one cycle → no rsp_valid, all outputs 0, ptr=0; the next request is granted from index 0.
